// File: rtl/slot_alloc.sv
// slot_alloc: allocator for N = 2^LG_N slots. Keeps a free vector, grants the
// req_cnt lowest-indexed free slots per accepted request through a one-entry
// grant register (EMPTY/HOLD), takes returned slots back, and flags protocol
// violations on a sticky err bit.
module slot_alloc #(
  parameter  int LG_N   = 4,
  parameter  int MAXREQ = 4,
  localparam int N      = 1 << LG_N,
  localparam int CW     = $clog2(MAXREQ + 1)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            req_valid,
  input  logic [CW-1:0]   req_cnt,
  output logic            req_ready,
  output logic            gnt_valid,
  output logic [N-1:0]    gnt_mask,
  input  logic            gnt_ready,
  input  logic            free_valid,
  input  logic [N-1:0]    free_mask,
  input  logic            flush,
  output logic [LG_N:0]   free_cnt,
  output logic            err
);

  typedef enum logic {S_EMPTY = 1'b0, S_HOLD = 1'b1} state_t;

  localparam logic [LG_N:0] N_C      = (LG_N+1)'(N);
  localparam logic [LG_N:0] MAXREQ_C = (LG_N+1)'(MAXREQ);

  state_t          r_state;
  logic [N-1:0]    r_vec;
  logic [N-1:0]    r_mask;
  logic [LG_N:0]   r_cnt;
  logic            r_err;

  logic [LG_N:0]   w_req;
  logic            w_oversize;
  logic            w_room;
  logic            w_accept;
  logic            w_dfree;
  logic [N-1:0]    w_sel;
  logic [N-1:0]    w_clr;
  logic [N-1:0]    w_ret;
  logic [N-1:0]    w_nxt;
  logic [LG_N:0]   w_nxt_cnt;

  // r_cnt always equals popcount(r_vec), so it can gate requests directly
  assign w_req      = (LG_N+1)'(req_cnt);
  assign w_oversize = w_req > MAXREQ_C;
  assign w_room     = (r_state == S_EMPTY) || gnt_ready;
  assign req_ready  = !flush && w_room && !w_oversize && (r_cnt >= w_req);
  assign w_accept   = req_valid && req_ready;
  assign w_dfree    = free_valid && ((free_mask & r_vec) != '0);

  // count-to-mask decode: take the req_cnt lowest-indexed free slots
  always_comb begin
    logic [LG_N:0] acc;
    acc   = '0;
    w_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (r_vec[i] && (acc < w_req)) begin
        w_sel[i] = 1'b1;
        acc      = acc + 1'b1;
      end
    end
  end

  // selection works on the pre-free vector; returned slots are OR'd in after
  assign w_clr = w_accept ? w_sel : '0;
  assign w_ret = free_valid ? free_mask : '0;
  assign w_nxt = (r_vec & ~w_clr) | w_ret;

  // popcount of the next free vector, registered into free_cnt
  always_comb begin
    w_nxt_cnt = '0;
    for (int i = 0; i < N; i++) w_nxt_cnt = w_nxt_cnt + (LG_N+1)'(w_nxt[i]);
  end

  // free vector, free count and sticky error; flush restores every slot
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vec <= '1;
      r_cnt <= N_C;
      r_err <= 1'b0;
    end else if (flush) begin
      r_vec <= '1;
      r_cnt <= N_C;
    end else begin
      r_vec <= w_nxt;
      r_cnt <= w_nxt_cnt;
      if (w_dfree || (req_valid && w_oversize)) r_err <= 1'b1;
    end
  end

  // grant register: EMPTY/HOLD with back-to-back reload on gnt_ready
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_EMPTY;
      r_mask  <= '0;
    end else if (flush) begin
      r_state <= S_EMPTY;
      r_mask  <= '0;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            r_state <= S_HOLD;
            r_mask  <= w_sel;
          end
        end
        S_HOLD: begin
          if (w_accept) begin
            r_mask  <= w_sel;
          end else if (gnt_ready) begin
            r_state <= S_EMPTY;
            r_mask  <= '0;
          end
        end
        default: begin
          r_state <= S_EMPTY;
          r_mask  <= '0;
        end
      endcase
    end
  end

  assign gnt_valid = (r_state == S_HOLD);
  assign gnt_mask  = r_mask;
  assign free_cnt  = r_cnt;
  assign err       = r_err;

endmodule

// File: tb/tb_slot_alloc.sv
// Bench for slot_alloc: directed vectors, a free-list model advanced at each
// clock edge, a negedge compare process, and hand-computed literal checks.
module tb_slot_alloc;
  localparam int LG_N = 4, N = 16, MAXREQ = 4, CW = 3;

  logic clk = 1'b0, reset_n = 1'b1;
  logic req_valid = 1'b0, gnt_ready = 1'b0, free_valid = 1'b0, flush = 1'b0;
  logic [CW-1:0] req_cnt = '0;
  logic [N-1:0]  free_mask = '0;
  logic          req_ready, gnt_valid, err;
  logic [N-1:0]  gnt_mask;
  logic [LG_N:0] free_cnt;

  int errs = 0, checks = 0;

  slot_alloc #(.LG_N(LG_N), .MAXREQ(MAXREQ)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_cnt(req_cnt),
    .req_ready(req_ready), .gnt_valid(gnt_valid), .gnt_mask(gnt_mask),
    .gnt_ready(gnt_ready), .free_valid(free_valid), .free_mask(free_mask),
    .flush(flush), .free_cnt(free_cnt), .err(err));

  always #5 clk = ~clk;

  // model state: set of free slots, pending grant, sticky error
  logic [N-1:0] m_vec = '1, m_mask = '0;
  logic m_valid = 1'b0, m_err = 1'b0;

  function automatic logic m_ready();
    return !flush && (!m_valid || gnt_ready) && (int'(req_cnt) <= MAXREQ)
           && ($countones(m_vec) >= int'(req_cnt));
  endfunction

  // list free slot indices in ascending order, hand out the first k
  function automatic logic [N-1:0] lowest(logic [N-1:0] v, int k);
    int idx[$];
    logic [N-1:0] r = '0;
    for (int i = 0; i < N; i++) if (v[i]) idx.push_back(i);
    for (int j = 0; j < k && j < idx.size(); j++) r[idx[j]] = 1'b1;
    return r;
  endfunction

  task automatic m_reset();
    m_vec = '1; m_mask = '0; m_valid = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_step();
    logic take;
    logic [N-1:0] sel;
    if (!reset_n) m_reset();
    else if (flush) begin
      m_vec = '1; m_mask = '0; m_valid = 1'b0;
    end else begin
      take = req_valid && m_ready();
      sel  = take ? lowest(m_vec, int'(req_cnt)) : '0;
      if (free_valid && ((free_mask & m_vec) != '0)) m_err = 1'b1;
      if (req_valid && int'(req_cnt) > MAXREQ) m_err = 1'b1;
      m_vec = (m_vec & ~sel) | (free_valid ? free_mask : '0);
      if (take) begin m_valid = 1'b1; m_mask = sel; end
      else if (gnt_ready) begin m_valid = 1'b0; m_mask = '0; end
    end
  endtask

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic drive(logic rv, logic [CW-1:0] rc, logic gr, logic fv,
                       logic [N-1:0] fm, logic fl);
    req_valid = rv; req_cnt = rc; gnt_ready = gr;
    free_valid = fv; free_mask = fm; flush = fl;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // compare process: every negedge, all outputs against the model
  always @(negedge clk) begin
    chk("m.gnt_valid", 32'(gnt_valid), 32'(m_valid));
    chk("m.gnt_mask",  32'(gnt_mask),  32'(m_mask));
    chk("m.free_cnt",  32'(free_cnt),  32'($countones(m_vec)));
    chk("m.err",       32'(err),       32'(m_err));
    chk("m.req_ready", 32'(req_ready), 32'(m_ready()));
  end

  typedef struct { logic rv; logic [CW-1:0] rc; logic gr; logic fv; logic [N-1:0] fm; } vec_t;
  vec_t tbl[6] = '{
    '{1'b1, 3'd2, 1'b1, 1'b0, 16'h0000},
    '{1'b1, 3'd3, 1'b1, 1'b1, 16'h0001},
    '{1'b1, 3'd4, 1'b1, 1'b0, 16'h0000},
    '{1'b1, 3'd1, 1'b0, 1'b0, 16'h0000},
    '{1'b0, 3'd0, 1'b1, 1'b1, 16'h00E1},
    '{1'b1, 3'd0, 1'b1, 1'b0, 16'h0000}
  };

  initial begin
    #1 reset_n = 1'b0; m_reset();
    #1;
    chk("rst.free_cnt", 32'(free_cnt), 32'd16);
    chk("rst.gnt_valid", 32'(gnt_valid), 32'd0);
    chk("rst.err", 32'(err), 32'd0);
    tick(); tick();
    reset_n = 1'b1;
    idle();

    // request of 3, then return those slots
    drive(1'b1, 3'd3, 1'b1, 1'b0, '0, 1'b0);
    chk("r3.ready", 32'(req_ready), 32'd1);
    tick();
    chk("r3.mask", 32'(gnt_mask), 32'h0007);
    chk("r3.cnt", 32'(free_cnt), 32'd13);
    chk("r3.valid", 32'(gnt_valid), 32'd1);
    idle(); tick();
    drive(1'b0, '0, 1'b1, 1'b1, 16'h0007, 1'b0); tick();
    chk("ret.cnt", 32'(free_cnt), 32'd16);

    // back-to-back 4,4,4,4 then 1
    drive(1'b1, 3'd4, 1'b1, 1'b0, '0, 1'b0); tick();
    chk("b2b.m0", 32'(gnt_mask), 32'h000F);
    tick(); chk("b2b.m1", 32'(gnt_mask), 32'h00F0);
    tick(); chk("b2b.m2", 32'(gnt_mask), 32'h0F00);
    tick(); chk("b2b.m3", 32'(gnt_mask), 32'hF000);
    chk("b2b.cnt", 32'(free_cnt), 32'd0);
    drive(1'b1, 3'd1, 1'b1, 1'b0, '0, 1'b0);
    chk("b2b.ready5", 32'(req_ready), 32'd0);
    tick(); idle();

    // free and request in the same cycle on an empty vector
    drive(1'b1, 3'd2, 1'b1, 1'b1, 16'h0102, 1'b0);
    chk("sim.ready", 32'(req_ready), 32'd0);
    tick();
    drive(1'b1, 3'd2, 1'b1, 1'b0, '0, 1'b0);
    chk("sim.ready2", 32'(req_ready), 32'd1);
    tick();
    chk("sim.mask", 32'(gnt_mask), 32'h0102);
    chk("sim.cnt", 32'(free_cnt), 32'd0);
    idle(); tick();

    // stall with gnt_ready low for 5 cycles
    drive(1'b0, '0, 1'b1, 1'b1, 16'hFFFF, 1'b0); tick();
    drive(1'b1, 3'd2, 1'b0, 1'b0, '0, 1'b0); tick();
    for (int k = 0; k < 5; k++) begin
      chk("stall.ready", 32'(req_ready), 32'd0);
      tick();
      chk("stall.mask", 32'(gnt_mask), 32'h0003);
    end
    drive(1'b1, 3'd2, 1'b1, 1'b0, '0, 1'b0);
    chk("rel.ready", 32'(req_ready), 32'd1);
    tick();
    chk("rel.mask", 32'(gnt_mask), 32'h000C);
    idle(); tick();

    // double free, then oversized request
    drive(1'b0, '0, 1'b1, 1'b1, 16'h0010, 1'b0); tick();
    chk("dfree.err", 32'(err), 32'd1);
    drive(1'b1, 3'd5, 1'b1, 1'b0, '0, 1'b0);
    chk("big.ready", 32'(req_ready), 32'd0);
    tick(); idle(); tick(); tick();
    chk("err.sticky", 32'(err), 32'd1);

    // flush during HOLD with a concurrent request
    drive(1'b1, 3'd1, 1'b0, 1'b0, '0, 1'b0); tick();
    chk("hold.mask", 32'(gnt_mask), 32'h0010);
    drive(1'b1, 3'd1, 1'b0, 1'b1, 16'h0001, 1'b1);
    chk("fl.ready", 32'(req_ready), 32'd0);
    tick();
    chk("fl.valid", 32'(gnt_valid), 32'd0);
    chk("fl.cnt", 32'(free_cnt), 32'd16);
    chk("fl.mask", 32'(gnt_mask), 32'h0000);
    chk("fl.err", 32'(err), 32'd1);

    // reset pulsed mid-grant
    drive(1'b1, 3'd2, 1'b0, 1'b0, '0, 1'b0); tick();
    #1 reset_n = 1'b0; m_reset();
    #1;
    chk("ar.valid", 32'(gnt_valid), 32'd0);
    chk("ar.cnt", 32'(free_cnt), 32'd16);
    chk("ar.mask", 32'(gnt_mask), 32'h0000);
    chk("ar.err", 32'(err), 32'd0);
    tick();
    reset_n = 1'b1;
    idle(); tick();

    // mixed table: overlap of accept and free, stalled HOLD, zero-size request
    foreach (tbl[i]) begin
      drive(tbl[i].rv, tbl[i].rc, tbl[i].gr, tbl[i].fv, tbl[i].fm, 1'b0);
      tick();
    end
    chk("tbl.zvalid", 32'(gnt_valid), 32'd1);
    chk("tbl.zmask", 32'(gnt_mask), 32'h0000);
    chk("tbl.zcnt", 32'(free_cnt), 32'd12);
    idle(); tick(); tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
